// File: rtl/rx_slot_ctrl_pkg.sv
// rx_slot_ctrl_pkg: shared definitions for the RX slot controller.
// Holds the receive FSM encoding and the CSR offsets the Wishbone
// decode uses for the head, fill and drop registers.
package rx_slot_ctrl_pkg;

  typedef enum logic [1:0] {
    RXS_IDLE    = 2'b00,
    RXS_RECV    = 2'b01,
    RXS_DISCARD = 2'b11
  } rxs_state_e;

  localparam logic [7:0] CSR_HEAD_OFS = 8'h00;
  localparam logic [7:0] CSR_FILL_OFS = 8'h04;
  localparam logic [7:0] CSR_DROP_OFS = 8'h08;

endpackage

// File: rtl/rx_slot_fifo.sv
// rx_slot_fifo: descriptor ring for committed RX frames.
// One length entry per slot. The slot index is the ring position itself.
// The tail pointer is exported so that payload writes land in the slot
// being filled. A pop is ignored while the ring is empty.
module rx_slot_fifo #(
  parameter int SLOT_AW = 2,
  parameter int LEN_W   = 12
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               push_i,
  input  logic [LEN_W-1:0]   push_len_i,
  input  logic               pop_i,
  output logic [SLOT_AW-1:0] tail_o,
  output logic               head_valid_o,
  output logic [SLOT_AW-1:0] head_slot_o,
  output logic [LEN_W-1:0]   head_len_o,
  output logic [SLOT_AW:0]   fill_cnt_o
);

  localparam int SLOTS = 2**SLOT_AW;
  localparam logic [SLOT_AW:0] FULL_CNT = (SLOT_AW+1)'(SLOTS);

  logic [LEN_W-1:0]   len_mem [SLOTS];
  logic [SLOT_AW-1:0] head_ptr;
  logic [SLOT_AW-1:0] tail_ptr;
  logic [SLOT_AW:0]   count;
  logic               pop_ok;
  logic               push_ok;

  assign pop_ok  = pop_i && (count != '0);
  assign push_ok = push_i && ((count != FULL_CNT) || pop_ok);

  // Ring pointers, occupancy and stored lengths; push and pop may share a cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        len_mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        len_mem[tail_ptr] <= push_len_i;
        tail_ptr          <= tail_ptr + SLOT_AW'(1);
      end
      if (pop_ok) begin
        head_ptr <= head_ptr + SLOT_AW'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + (SLOT_AW+1)'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - (SLOT_AW+1)'(1);
      end
    end
  end

  assign tail_o       = tail_ptr;
  assign head_valid_o = (count != '0);
  assign head_slot_o  = head_ptr;
  assign head_len_o   = len_mem[head_ptr];
  assign fill_cnt_o   = count;

endmodule

// File: rtl/rx_slot_ctrl.sv
// rx_slot_ctrl: sequences received UDP payload into a ring of RX memory slots.
// It allocates a slot per frame, writes the bytes one cycle after they are
// accepted, commits or discards the frame, and presents the oldest committed
// frame to the CSR side. Optional macro RX_SLOT_IRQ_EN enables irq_o.
// Without that macro, irq_o is tied low.
module rx_slot_ctrl
  import rx_slot_ctrl_pkg::*;
#(
  parameter int OCT     = 8,
  parameter int SLOT_AW = 2,
  parameter int BYTE_AW = 11,
  parameter int DROP_W  = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       frm_start_i,
  input  logic                       frm_data_v_i,
  input  logic [OCT-1:0]             frm_data_i,
  input  logic                       frm_end_i,
  input  logic                       frm_err_i,
  output logic                       mem_we_o,
  output logic [SLOT_AW+BYTE_AW-1:0] mem_waddr_o,
  output logic [OCT-1:0]             mem_wdata_o,
  input  logic                       host_pop_i,
  output logic                       head_valid_o,
  output logic [SLOT_AW-1:0]         head_slot_o,
  output logic [BYTE_AW:0]           head_len_o,
  output logic [SLOT_AW:0]           fill_cnt_o,
  output logic [DROP_W-1:0]          drop_cnt_o,
  output logic                       busy_o,
  input  logic                       irq_en_i,
  output logic                       irq_o
);

  localparam logic [BYTE_AW:0] SLOT_BYTES = (BYTE_AW+1)'(2**BYTE_AW);
  localparam logic [SLOT_AW:0] RING_FULL  = (SLOT_AW+1)'(2**SLOT_AW);

  rxs_state_e         state;
  rxs_state_e         state_n;
  logic [BYTE_AW:0]   byte_cnt;
  logic [BYTE_AW:0]   commit_len;
  logic [SLOT_AW-1:0] tail;
  logic               ring_full;
  logic               wr_en;
  logic               cnt_clr;
  logic               cnt_inc;
  logic               commit;
  logic               drop_inc;
  logic               drop_bump;

  assign ring_full  = (fill_cnt_o == RING_FULL);
  assign commit_len = byte_cnt + (BYTE_AW+1)'(frm_data_v_i);
  assign drop_bump  = drop_inc && !(&drop_cnt_o);
  assign busy_o     = (state != RXS_IDLE);

  rx_slot_fifo #(
    .SLOT_AW (SLOT_AW),
    .LEN_W   (BYTE_AW+1)
  ) u_fifo (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .push_i       (commit),
    .push_len_i   (commit_len),
    .pop_i        (host_pop_i),
    .tail_o       (tail),
    .head_valid_o (head_valid_o),
    .head_slot_o  (head_slot_o),
    .head_len_o   (head_len_o),
    .fill_cnt_o   (fill_cnt_o)
  );

  // Receive FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= RXS_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and per-cycle actions; a new start outranks data and end
  always_comb begin
    state_n  = state;
    wr_en    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    commit   = 1'b0;
    drop_inc = 1'b0;
    case (state)
      RXS_IDLE, RXS_DISCARD: begin
        if (frm_start_i) begin
          cnt_clr = 1'b1;
          if (ring_full) begin
            state_n  = RXS_DISCARD;
            drop_inc = 1'b1;
          end else begin
            state_n = RXS_RECV;
          end
        end else if (frm_end_i && (state == RXS_DISCARD)) begin
          state_n = RXS_IDLE;
        end
      end
      RXS_RECV: begin
        if (frm_start_i) begin
          drop_inc = 1'b1;
          cnt_clr  = 1'b1;
        end else if (frm_data_v_i && (byte_cnt == SLOT_BYTES)) begin
          drop_inc = 1'b1;
          state_n  = frm_end_i ? RXS_IDLE : RXS_DISCARD;
        end else begin
          if (frm_data_v_i) begin
            wr_en   = 1'b1;
            cnt_inc = 1'b1;
          end
          if (frm_end_i) begin
            state_n = RXS_IDLE;
            if (frm_err_i) begin
              drop_inc = 1'b1;
            end else begin
              commit = 1'b1;
            end
          end
        end
      end
      default: begin
        state_n = RXS_IDLE;
      end
    endcase
  end

  // Byte counter and registered write port into the current tail slot
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      byte_cnt    <= '0;
      mem_we_o    <= 1'b0;
      mem_waddr_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      mem_we_o <= wr_en;
      if (wr_en) begin
        mem_waddr_o <= {tail, byte_cnt[BYTE_AW-1:0]};
        mem_wdata_o <= frm_data_i;
      end
      if (cnt_clr) begin
        byte_cnt <= '0;
      end else if (cnt_inc) begin
        byte_cnt <= byte_cnt + (BYTE_AW+1)'(1);
      end
    end
  end

  // Saturating dropped-frame counter, cleared only by reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      drop_cnt_o <= '0;
    end else if (drop_bump) begin
      drop_cnt_o <= drop_cnt_o + DROP_W'(1);
    end
  end

`ifdef RX_SLOT_IRQ_EN
  // Level while frames are pending, plus a one-cycle pulse on each counted drop
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= irq_en_i && (head_valid_o || drop_bump);
    end
  end
`else
  logic unused_irq_en;
  assign unused_irq_en = irq_en_i;
  assign irq_o         = 1'b0;
`endif

endmodule
